// File: rtl/reg4_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// Module      : reg4_write_arbiter_if
// Description : Request/acknowledge bus between four write clients and the
//               shared-register write arbiter. Clients use the master view,
//               the arbiter uses the slave view.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface reg4_write_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req;      // one request bit per client
  logic [4*WIDTH-1:0] data_in;  // lane i = data_in[i*WIDTH +: WIDTH]
  logic [3:0]         grant;    // one-hot winner, 0 when idle
  logic [3:0]         ack;      // one-hot, one-cycle commit pulse
  logic               reg_en;   // load enable into the shared register
  logic [WIDTH-1:0]   reg_d;    // latched winner data
  logic [WIDTH-1:0]   q;        // shared register contents
  logic               busy;     // arbiter not idle

  modport master (
    output req, data_in,
    input  grant, ack, reg_en, reg_d, q, busy
  );

  modport slave (
    input  req, data_in,
    output grant, ack, reg_en, reg_d, q, busy
  );
endinterface

`default_nettype wire

// File: rtl/reg4_write_arbiter.sv
// ---------------------------------------------------------------------------
// Module      : reg4_write_arbiter
// Description : Arbitrates four write requesters onto one shared WIDTH-bit
//               load-enable register. Each write takes three cycles:
//               IDLE (sample/grant) -> WRITE (reg_en) -> ACK (ack pulse).
//               Build option: define REG4_ARB_FIXED_PRIO_EN for fixed
//               priority (req[0] highest); otherwise round-robin.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

// Shared storage element: async-reset register that loads on enable.
module reg4_war_dreg #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Hold contents unless enabled; reset clears immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

module reg4_write_arbiter #(
  parameter int WIDTH = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  reg4_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_grant;
  logic [WIDTH-1:0] r_reg_d;
  logic [WIDTH-1:0] w_q;

  logic [1:0]       w_win;
  logic             w_any;
  logic             w_load_grant;
  logic             w_clr_grant;
  logic             w_reg_en;
  logic [3:0]       w_ack;

  assign w_any = |bus.req;

`ifdef REG4_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-numbered active request wins.
  always_comb begin
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) begin
        w_win = 2'(k);
      end
    end
  end
`else
  logic [1:0] r_ptr;  // last winner; search starts just after it
  logic [1:0] r_win;  // winner of the transaction in flight

  // Round-robin: first active request in order ptr+1, ptr+2, ptr+3, ptr.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    w_win = r_ptr;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        w_win = idx;
        found = 1'b1;
      end
    end
  end

  // Capture the winner at grant time and retire it into ptr on ACK exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd3;
      r_win <= 2'd0;
    end else begin
      if (w_load_grant) begin
        r_win <= w_win;
      end
      if (w_clr_grant) begin
        r_ptr <= r_win;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state controls; requests are looked at only in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    w_clr_grant  = 1'b0;
    w_reg_en     = 1'b0;
    w_ack        = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load_grant = 1'b1;
          w_state_nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        w_reg_en    = 1'b1;
        w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_ack       = r_grant;
        w_clr_grant = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant and data are latched together so later data_in changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= 4'b0000;
      r_reg_d <= '0;
    end else if (w_load_grant) begin
      r_grant <= 4'd1 << w_win;
      r_reg_d <= bus.data_in[w_win*WIDTH +: WIDTH];
    end else if (w_clr_grant) begin
      r_grant <= 4'b0000;
    end
  end

  reg4_war_dreg #(
    .WIDTH (WIDTH)
  ) u_dreg (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_reg_en),
    .i_d   (r_reg_d),
    .o_q   (w_q)
  );

  assign bus.grant  = r_grant;
  assign bus.ack    = w_ack;
  assign bus.reg_en = w_reg_en;
  assign bus.reg_d  = r_reg_d;
  assign bus.q      = w_q;
  assign bus.busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reg4_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_reg4_write_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  reg4_write_arbiter_if #(.WIDTH(4)) bus ();

  reg4_write_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        en;
    logic [3:0]  regd;
    logic [3:0]  q;
    logic        busy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] g, input logic [3:0] a,
                         input logic e, input logic [3:0] rd, input logic [3:0] qq,
                         input logic b);
    chk({nm, ".grant"},  32'(bus.grant),  32'(g));
    chk({nm, ".ack"},    32'(bus.ack),    32'(a));
    chk({nm, ".reg_en"}, 32'(bus.reg_en), 32'(e));
    chk({nm, ".reg_d"},  32'(bus.reg_d),  32'(rd));
    chk({nm, ".q"},      32'(bus.q),      32'(qq));
    chk({nm, ".busy"},   32'(bus.busy),   32'(b));
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic [3:0] r, input logic [15:0] d);
    @(negedge clk);
    bus.req     = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  logic [3:0] exp_g [4];
  logic [3:0] exp_q [4];

  initial begin
    total = 0;
    bad   = 0;

    // Table starts at E1 of the first write that follows reset release.
    tbl[0]  = '{4'b1111, 16'h4321, 4'b0001, 4'b0001, 1'b0, 4'h1, 4'h1, 1'b1};
    tbl[1]  = '{4'b1110, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h1, 4'h1, 1'b0};
    tbl[2]  = '{4'b1110, 16'h4321, 4'b0010, 4'b0000, 1'b1, 4'h2, 4'h1, 1'b1};
    tbl[3]  = '{4'b1110, 16'h4321, 4'b0010, 4'b0010, 1'b0, 4'h2, 4'h2, 1'b1};
    tbl[4]  = '{4'b1100, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h2, 4'h2, 1'b0};
    tbl[5]  = '{4'b1100, 16'h4321, 4'b0100, 4'b0000, 1'b1, 4'h3, 4'h2, 1'b1};
    tbl[6]  = '{4'b1100, 16'h4321, 4'b0100, 4'b0100, 1'b0, 4'h3, 4'h3, 1'b1};
    tbl[7]  = '{4'b1000, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h3, 4'h3, 1'b0};
    tbl[8]  = '{4'b1000, 16'h4321, 4'b1000, 4'b0000, 1'b1, 4'h4, 4'h3, 1'b1};
    tbl[9]  = '{4'b1000, 16'h4321, 4'b1000, 4'b1000, 1'b0, 4'h4, 4'h4, 1'b1};
    tbl[10] = '{4'b1111, 16'h4321, 4'b0000, 4'b0000, 1'b0, 4'h4, 4'h4, 1'b0};
    tbl[11] = '{4'b1111, 16'h4321, 4'b0001, 4'b0000, 1'b1, 4'h1, 4'h4, 1'b1};
    tbl[12] = '{4'b1111, 16'h9999, 4'b0001, 4'b0001, 1'b0, 4'h1, 4'h1, 1'b1};
    tbl[13] = '{4'b1110, 16'h8765, 4'b0000, 4'b0000, 1'b0, 4'h1, 4'h1, 1'b0};
    tbl[14] = '{4'b1110, 16'h8765, 4'b0010, 4'b0000, 1'b1, 4'h6, 4'h1, 1'b1};
    tbl[15] = '{4'b1110, 16'h8765, 4'b0010, 4'b0010, 1'b0, 4'h6, 4'h6, 1'b1};
    tbl[16] = '{4'b0000, 16'h8765, 4'b0000, 4'b0000, 1'b0, 4'h6, 4'h6, 1'b0};
    tbl[17] = '{4'b0000, 16'h8765, 4'b0000, 4'b0000, 1'b0, 4'h6, 4'h6, 1'b0};

`ifdef REG4_ARB_FIXED_PRIO_EN
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010; exp_g[3] = 4'b0010;
    exp_q[0] = 4'hE;    exp_q[1] = 4'hE;    exp_q[2] = 4'hE;    exp_q[3] = 4'hE;
`else
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0010;
    exp_q[0] = 4'hD;    exp_q[1] = 4'hE;    exp_q[2] = 4'hD;    exp_q[3] = 4'hE;
`endif

    // Reset held with all requests high: everything stays cleared.
    reset       = 1'b1;
    bus.req     = 4'b1111;
    bus.data_in = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b0);

    // Release: the very next edge arbitrates and req[0] wins.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rel_e0", 4'b0001, 4'b0000, 1'b1, 4'h1, 4'h0, 1'b1);

    // Round-robin sweep, re-raise, and data-change-after-grant.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].din);
      chk_all($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].ack, tbl[i].en,
              tbl[i].regd, tbl[i].q, tbl[i].busy);
    end

    // Late request: req[2] rises during requester 0's WRITE.
    step(4'b0001, 16'h0B0A);
    chk_all("late_e0", 4'b0001, 4'b0000, 1'b1, 4'hA, 4'h6, 1'b1);
    step(4'b0101, 16'h0B0A);
    chk_all("late_e1", 4'b0001, 4'b0001, 1'b0, 4'hA, 4'hA, 1'b1);
    step(4'b0100, 16'h0B0A);
    chk_all("late_e2", 4'b0000, 4'b0000, 1'b0, 4'hA, 4'hA, 1'b0);
    step(4'b0100, 16'h0B0A);
    chk_all("late_e3", 4'b0100, 4'b0000, 1'b1, 4'hB, 4'hA, 1'b1);
    step(4'b0100, 16'h0B0A);
    chk_all("late_e4", 4'b0100, 4'b0100, 1'b0, 4'hB, 4'hB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 16'h0B0A);
      chk_all($sformatf("late_quiet%0d", i), 4'b0000, 4'b0000, 1'b0, 4'hB, 4'hB, 1'b0);
    end

    // Reset mid-WRITE: preload q=5, then abort a write of 4'hC.
    step(4'b0001, 16'h0005);
    step(4'b0001, 16'h0005);
    chk_all("pre5", 4'b0001, 4'b0001, 1'b0, 4'h5, 4'h5, 1'b1);
    step(4'b0000, 16'h0005);
    step(4'b0010, 16'h00C0);
    chk_all("abort_e0", 4'b0010, 4'b0000, 1'b1, 4'hC, 4'h5, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("abort_rst", 4'b0000, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("abort_hold", 4'b0000, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b0);
    // Release with req[0] and req[1]: ptr back at 3 means req[0] goes first.
    @(negedge clk);
    reset       = 1'b0;
    bus.req     = 4'b0011;
    bus.data_in = 16'h00C7;
    @(posedge clk);
    #1;
    chk_all("rearb_e0", 4'b0001, 4'b0000, 1'b1, 4'h7, 4'h0, 1'b1);
    step(4'b0011, 16'h00C7);
    chk_all("rearb_e1", 4'b0001, 4'b0001, 1'b0, 4'h7, 4'h7, 1'b1);
    step(4'b0010, 16'h00C7);
    step(4'b0010, 16'h00C7);
    chk_all("rewr_e0", 4'b0010, 4'b0000, 1'b1, 4'hC, 4'h7, 1'b1);
    step(4'b0010, 16'h00C7);
    chk_all("rewr_e1", 4'b0010, 4'b0010, 1'b0, 4'hC, 4'hC, 1'b1);
    step(4'b0000, 16'h00C7);
    chk_all("rewr_e2", 4'b0000, 4'b0000, 1'b0, 4'hC, 4'hC, 1'b0);

    // req[1] and req[3] held continuously: round-robin alternates, fixed
    // priority keeps picking requester 1.
    for (int t = 0; t < 4; t++) begin
      step(4'b1010, 16'hD0E0);
      chk($sformatf("pair%0d.grant", t), 32'(bus.grant), 32'(exp_g[t]));
      step(4'b1010, 16'hD0E0);
      chk($sformatf("pair%0d.ack", t), 32'(bus.ack), 32'(exp_g[t]));
      chk($sformatf("pair%0d.q", t), 32'(bus.q), 32'(exp_q[t]));
      step(4'b1010, 16'hD0E0);
      chk($sformatf("pair%0d.busy", t), 32'(bus.busy), 32'(1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
